// File: rtl/crc_tx_framer_pkg.sv
// Shared constants, FSM state type and byte-reversal helper for the CRC-16 transmit framer.
package crc_tx_framer_pkg;

  localparam logic [16:0] CRC16_MASK  = 17'h1_1021;
  localparam logic [15:0] CRC16_POLY  = CRC16_MASK[15:0];
  localparam logic [15:0] CRC16_INIT  = 16'h0000;
  localparam int          FRAME_BYTES = 5;
  localparam int          MSG_BITS    = 24;

  typedef enum logic [2:0] {
    IDLE,
    CRC,
    LOAD,
    SEND,
    DONE
  } state_e;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/crc_tx_framer_if.sv
// Message handshake between the message source (master) and the framer (slave).
interface crc_tx_framer_if;
  import crc_tx_framer_pkg::*;

  logic [MSG_BITS-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/crc_tx_framer_uart_tx.sv
// uart_tx: 8N1 serialiser; one line bit per tick_i, start bit on the first tick after start_i.
module crc_tx_framer_uart_tx (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  logic [7:0] buf_q, buf_d;
  logic [7:0] shift_q, shift_d;
  logic       pend_q, pend_d;
  logic [3:0] cnt_q, cnt_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;

  // cnt_q: 0 line idle, 1 start bit, 2..9 data bits, 10 stop bit on the line.
  // done fires as the stop bit goes out so a queued byte launches on the tick that ends it.
  always_comb begin
    buf_d   = buf_q;
    shift_d = shift_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (start_i) begin
      buf_d  = data_i;
      pend_d = 1'b1;
    end
    if (tick_i) begin
      if (cnt_q == 4'd0 || cnt_q == 4'd10) begin
        if (pend_q) begin
          tx_d    = 1'b0;
          shift_d = buf_q;
          pend_d  = start_i;
          cnt_d   = 4'd1;
        end else begin
          tx_d  = 1'b1;
          cnt_d = 4'd0;
        end
      end else if (cnt_q == 4'd9) begin
        tx_d   = 1'b1;
        cnt_d  = 4'd10;
        done_d = 1'b1;
      end else begin
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
        cnt_d   = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q   <= 8'h00;
      shift_q <= 8'h00;
      pend_q  <= 1'b0;
      cnt_q   <= 4'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      shift_q <= shift_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = pend_q || (cnt_q != 4'd0);
  assign done_o = done_q;

endmodule

// File: rtl/crc_tx_framer.sv
// CRC-16 transmit framer: LFSR over a 24-bit message, then a 5-byte 8N1 frame {M, C}.
// Optional CRC_TX_ERR_INJECT_EN adds err_inject_i, which flips C[0] on the wire only.
module crc_tx_framer
  import crc_tx_framer_pkg::*;
#(
  parameter logic [15:0] POLY     = CRC16_POLY,
  parameter logic [15:0] CRC_INIT = CRC16_INIT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_i,
  crc_tx_framer_if.slave        msg,
`ifdef CRC_TX_ERR_INJECT_EN
  input  logic                  err_inject_i,
`endif
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           crc_o
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
  localparam logic [4:0] BIT_TOP  = 5'(MSG_BITS - 1);

  state_e              state_q, state_d;
  logic [MSG_BITS-1:0] msg_q, msg_d;
  logic [15:0]         crc_q, crc_d;
  logic [15:0]         crc_out_q, crc_out_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [15:0]         crc_step;
  logic [7:0]          byte_sel;
  logic [7:0]          uart_data;
  logic                uart_start, uart_busy, uart_done;
  logic                inj_q;

`ifdef CRC_TX_ERR_INJECT_EN
  logic inj_d;
`else
  assign inj_q = 1'b0;
`endif

  assign crc_step = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ msg_q[bit_cnt_q]) ? POLY : 16'h0000);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (msg.valid) state_d = CRC;
      CRC:  if (bit_cnt_q == 5'd0) state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: begin
        if (idx_q != LAST_IDX) begin
          if (uart_done) state_d = LOAD;
        end else if (!uart_busy) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    msg.ready  = (state_q == IDLE);
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    uart_start = (state_q == LOAD);
  end

  always_comb begin
    msg_d     = msg_q;
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
`ifdef CRC_TX_ERR_INJECT_EN
    inj_d     = inj_q;
`endif
    case (state_q)
      IDLE: if (msg.valid) begin
        msg_d     = msg.data;
        crc_d     = CRC_INIT;
        bit_cnt_d = BIT_TOP;
`ifdef CRC_TX_ERR_INJECT_EN
        inj_d     = err_inject_i;
`endif
      end
      CRC: begin
        crc_d     = crc_step;
        bit_cnt_d = bit_cnt_q - 5'd1;
        if (bit_cnt_q == 5'd0) begin
          crc_out_d = crc_step;
          idx_d     = 3'd0;
          bit_cnt_d = 5'd0;
        end
      end
      SEND: if (idx_q != LAST_IDX && uart_done) idx_d = idx_q + 3'd1;
      default: ;
    endcase
  end

  // Low CRC byte goes first; the injected error touches only this copy, never crc_o.
  always_comb begin
    case (idx_q)
      3'd0:    byte_sel = crc_out_q[7:0] ^ {7'b0, inj_q};
      3'd1:    byte_sel = crc_out_q[15:8];
      3'd2:    byte_sel = msg_q[7:0];
      3'd3:    byte_sel = msg_q[15:8];
      default: byte_sel = msg_q[23:16];
    endcase
    uart_data = rev8(byte_sel);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msg_q     <= '0;
      crc_q     <= '0;
      crc_out_q <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
`ifdef CRC_TX_ERR_INJECT_EN
      inj_q     <= 1'b0;
`endif
    end else begin
      msg_q     <= msg_d;
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
`ifdef CRC_TX_ERR_INJECT_EN
      inj_q     <= inj_d;
`endif
    end
  end

  assign crc_o = crc_out_q;

  crc_tx_framer_uart_tx u_uart_tx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tick_i  (tick_i),
    .data_i  (uart_data),
    .start_i (uart_start),
    .tx_o    (tx_o),
    .busy_o  (uart_busy),
    .done_o  (uart_done)
  );

endmodule

// File: tb/tb_crc_tx_framer.sv
// Scoreboard bench for crc_tx_framer: a UART-line monitor decodes characters and checks
// bytes, CRC, frame length and frame residue against expectations queued at stimulus time.
module tb_crc_tx_framer;

  localparam int TICK_DIV = 8;

  typedef struct packed {
    logic [15:0] crc;
    logic [15:0] residue;
  } frame_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        tx, busy, done;
  logic [15:0] crc;
`ifdef CRC_TX_ERR_INJECT_EN
  logic        err_inject;
`endif

  crc_tx_framer_if msg_if ();

  crc_tx_framer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tick_i       (tick),
    .msg          (msg_if),
`ifdef CRC_TX_ERR_INJECT_EN
    .err_inject_i (err_inject),
`endif
    .tx_o         (tx),
    .busy_o       (busy),
    .done_o       (done),
    .crc_o        (crc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rx_chars = 0;

  logic [7:0] exp_byte_q[$];
  frame_exp_t exp_frame_q[$];

  int          rx_state = 0;
  int          rx_cnt = 0;
  int          byte_idx = 0;
  int          tick_no = 0;
  int          frame_start = 0;
  bit          in_frame = 1'b0;
  logic [7:0]  rx_bits;
  logic [39:0] rx_word;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Long division of the reassembled 40-bit word by x^16+x^12+x^5+1.
  function automatic logic [15:0] residue40(input logic [39:0] w);
    logic [39:0] r;
    r = w;
    for (int i = 39; i >= 16; i--)
      if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h1_1021;
    return r[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    n_cmp++;
    n_err++;
    $display("[TB] FAIL %s: got an event or timeout, expected none", name);
  endtask

  task automatic pushExpect(input logic [23:0] m, input logic [15:0] c, input logic err);
    exp_byte_q.push_back(rev8(c[7:0] ^ {7'b0, err}));
    exp_byte_q.push_back(rev8(c[15:8]));
    exp_byte_q.push_back(rev8(m[7:0]));
    exp_byte_q.push_back(rev8(m[15:8]));
    exp_byte_q.push_back(rev8(m[23:16]));
    exp_frame_q.push_back({c, {15'b0, err}});
  endtask

  task automatic applyStimulus(input logic [23:0] m, input logic [15:0] c, input logic err,
                               input bit hold);
    int i;
    @(negedge clk);
    msg_if.data  = m;
    msg_if.valid = 1'b1;
`ifdef CRC_TX_ERR_INJECT_EN
    err_inject = err;
`endif
    pushExpect(m, c, err);
    i = 0;
    while (!msg_if.ready && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (!msg_if.ready) begin
      failNow("handshake_timeout");
      msg_if.valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) msg_if.valid = 1'b0;
  endtask

  task automatic waitDone();
    int  start;
    bit  seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      failNow("done_timeout");
    end else begin
      checkOutput("ready_during_done", 40'(msg_if.ready), 40'd0);
      @(negedge clk);
      checkOutput("ready_after_done", 40'(msg_if.ready), 40'd1);
    end
  endtask

  initial begin
    tick = 1'b0;
    forever begin
      for (int k = 0; k < TICK_DIV - 1; k++) begin
        @(negedge clk);
        tick = 1'b0;
      end
      @(negedge clk);
      tick = 1'b1;
    end
  end

  // Line monitor: one sample per tick interval, 8N1 decode, frame checks on done.
  initial begin : monitor
    bit          t;
    logic [7:0]  eb;
    frame_exp_t  fe;
    forever begin
      @(posedge clk);
      t = tick;
      #1;
      if (rst) begin
        rx_state = 0;
        in_frame = 1'b0;
        byte_idx = 0;
        rx_word  = '0;
        continue;
      end
      if (t) begin
        tick_no++;
        case (rx_state)
          0: if (tx == 1'b0) begin
            rx_state = 1;
            rx_cnt   = 0;
            if (!in_frame) begin
              in_frame    = 1'b1;
              frame_start = tick_no;
              byte_idx    = 0;
              rx_word     = '0;
            end
          end
          1: begin
            rx_bits[rx_cnt] = tx;
            rx_cnt++;
            if (rx_cnt == 8) rx_state = 2;
          end
          default: begin
            checkOutput("stop_bit", 40'(tx), 40'd1);
            if (exp_byte_q.size() == 0) begin
              failNow("unexpected_byte");
            end else begin
              eb = exp_byte_q.pop_front();
              checkOutput("uart_byte", 40'(rx_bits), 40'(eb));
            end
            if (byte_idx < 5) rx_word[byte_idx*8 +: 8] = rev8(rx_bits);
            byte_idx++;
            rx_chars++;
            rx_state = 0;
          end
        endcase
      end
      if (done) begin
        done_cnt++;
        if (exp_frame_q.size() == 0) begin
          failNow("unexpected_done");
        end else begin
          fe = exp_frame_q.pop_front();
          checkOutput("crc_o", 40'(crc), 40'(fe.crc));
          checkOutput("frame_residue", 40'(residue40(rx_word)), 40'(fe.residue));
          checkOutput("frame_ticks", 40'(tick_no - frame_start), 40'd50);
          checkOutput("frame_bytes", 40'(byte_idx), 40'd5);
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int d0;
    rst          = 1'b1;
    msg_if.valid = 1'b0;
    msg_if.data  = '0;
`ifdef CRC_TX_ERR_INJECT_EN
    err_inject   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 40'(tx), 40'd1);
    checkOutput("reset_ready", 40'(msg_if.ready), 40'd1);
    checkOutput("reset_busy", 40'(busy), 40'd0);
    checkOutput("reset_done", 40'(done), 40'd0);
    checkOutput("reset_crc", 40'(crc), 40'd0);
    rst = 1'b0;

    $display("[TB] frame M=000001");
    applyStimulus(24'h000001, 16'h1021, 1'b0, 1'b0);
    waitDone();

    $display("[TB] frame M=000002 with ignored valid mid-frame");
    applyStimulus(24'h000002, 16'h2042, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    checkOutput("ready_mid_frame", 40'(msg_if.ready), 40'd0);
    checkOutput("busy_mid_frame", 40'(busy), 40'd1);
    msg_if.data  = 24'hFFFFFF;
    msg_if.valid = 1'b1;
    @(negedge clk);
    msg_if.valid = 1'b0;
    waitDone();

    $display("[TB] frame M=000000");
    applyStimulus(24'h000000, 16'h0000, 1'b0, 1'b0);
    waitDone();

    $display("[TB] back-to-back M=000003 then M=000010");
    applyStimulus(24'h000003, 16'h3063, 1'b0, 1'b1);
    msg_if.data = 24'h000010;
    pushExpect(24'h000010, 16'h1231, 1'b0);
    waitDone();
    @(negedge clk);
    checkOutput("b2b_accepted", 40'(busy), 40'd1);
    msg_if.valid = 1'b0;
    waitDone();

    $display("[TB] reset during byte2");
    applyStimulus(24'h000010, 16'h1231, 1'b0, 1'b0);
    base = rx_chars;
    for (int i = 0; i < 3000 && rx_chars < base + 2; i++) @(negedge clk);
    if (rx_chars < base + 2) failNow("byte2_timeout");
    repeat (3 * TICK_DIV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_tx", 40'(tx), 40'd1);
    checkOutput("abort_ready", 40'(msg_if.ready), 40'd1);
    checkOutput("abort_crc", 40'(crc), 40'd0);
    checkOutput("abort_done", 40'(done), 40'd0);
    rst = 1'b0;
    exp_byte_q.delete();
    exp_frame_q.delete();
    d0 = done_cnt;
    repeat (200) @(negedge clk);
    checkOutput("no_done_after_reset", 40'(done_cnt), 40'(d0));
    checkOutput("tx_idle_after_reset", 40'(tx), 40'd1);

    $display("[TB] frame M=000001 after reset");
    applyStimulus(24'h000001, 16'h1021, 1'b0, 1'b0);
    waitDone();

`ifdef CRC_TX_ERR_INJECT_EN
    $display("[TB] frame M=000001 with error injection");
    applyStimulus(24'h000001, 16'h1021, 1'b1, 1'b0);
    waitDone();
    err_inject = 1'b0;
`endif

    repeat (20) @(negedge clk);
    checkOutput("leftover_bytes", 40'(exp_byte_q.size()), 40'd0);
    checkOutput("leftover_frames", 40'(exp_frame_q.size()), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no end of run, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
